// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

package instr_fetch_pkg;

    localparam int DEF_ADDR_W = `PC_SIZE;
    localparam int DEF_DATA_W = 32;

    // Instruction placed in the register on reset and on any failed fetch.
    localparam logic [DEF_DATA_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bundle between fetch unit and memory.
// Latency: n/a (wires only).
// Backpressure: imem_req is a level held until the one-cycle imem_ack strobe.
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output imem_err
    );

endinterface

// File: rtl/instr_fetch_timer.sv
// Request watchdog: counts cycles spent waiting for imem_ack, saturating at TIMEOUT.
// Latency: done asserts combinationally once the count reaches TIMEOUT-1.
// Backpressure: none; TIMEOUT=0 keeps done low forever.
module instr_fetch_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic Clock,
    input  logic nReset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] CNT_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] CNT_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    logic [TW-1:0] count;

    // Cycle counter: cleared on request entry, stops at CNT_MAX instead of wrapping.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + TW'(1);
        end
    end

    assign done = (TIMEOUT != 0) && (count == CNT_LAST);

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: takes the PC, runs req/ack to instruction memory, holds the word in instr.
// Latency: ack on cycle N gives instr_valid on N+1; at least 2 cycles per instruction.
// Backpressure: pause holds the PC until a word is held and stall_in is low.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          ADDR_W  = DEF_ADDR_W,
    parameter int          DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic              stall_in,
    output logic              pause,
    instr_fetch_if.master     imem,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_err
);

    localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INSTR);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic              valid_nxt;
    logic              err_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              misaligned;
    logic              timer_clr;
    logic              timer_en;
    logic              timer_done;

    // Only 32-bit words carry an alignment requirement on the low two address bits.
    assign misaligned = (DATA_W == 32) && (instr_addr[1:0] != 2'b00);

    instr_fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .Clock  (Clock),
        .nReset (nReset),
        .clear  (timer_clr),
        .enable (timer_en),
        .done   (timer_done)
    );

    // Next-state and register updates: decide how the current request ends.
    always_comb begin
        state_nxt = state;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        err_nxt   = fetch_err;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = REQ;
                timer_clr = 1'b1;
            end
            REQ: begin
                if (misaligned) begin
                    state_nxt = VALID;
                    instr_nxt = NOP;
                    err_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                end else if (imem.imem_ack) begin
                    // An ack arriving with the timeout still counts as a completion.
                    state_nxt = VALID;
                    valid_nxt = 1'b1;
                    if (imem.imem_err) begin
                        instr_nxt = NOP;
                        err_nxt   = 1'b1;
                    end else begin
                        instr_nxt = imem.imem_rdata;
                    end
                end else if (timer_done) begin
                    state_nxt = VALID;
                    instr_nxt = NOP;
                    err_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            VALID: begin
                if (!stall_in) begin
                    state_nxt = REQ;
                    valid_nxt = 1'b0;
                    timer_clr = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state       <= IDLE;
            instr       <= NOP;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            addr_q      <= '0;
        end else begin
            state       <= state_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            fetch_err   <= err_nxt;
            if (state == REQ) begin
                addr_q <= instr_addr;
            end
        end
    end

    // The PC moves on the same edge that enters REQ, so during REQ the live instr_addr
    // is already the updated PC and stays frozen by pause; addr_q keeps the last
    // requested address visible outside a request.
    assign imem.imem_addr = (state == REQ) ? instr_addr : addr_q;
    assign imem.imem_req  = (state == REQ) && !misaligned;

    assign pause = !nReset || (state != VALID) || stall_in;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic against a model.
// Latency: model predicts every cycle's outputs from the fetch rules.
// Backpressure: random stall_in and memory latency, spurious acks, random resets.
module tb_instr_fetch;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_HOLD = 2;

    logic          Clock = 1'b0;
    logic          nReset;
    logic [AW-1:0] instr_addr;
    logic          stall_in;
    logic          pause;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          fetch_err;

    instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    instr_fetch #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .instr_addr  (instr_addr),
        .stall_in    (stall_in),
        .pause       (pause),
        .imem        (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err)
    );

    always #5 Clock = ~Clock;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state: what the fetch unit is doing and what it holds.
    int          m_phase = PH_IDLE;
    int          m_wait  = 0;
    logic [31:0] m_instr = '0;
    bit          m_valid = 1'b0;
    bit          m_err   = 1'b0;
    bit          m_known = 1'b0;
    logic [31:0] pc      = '0;
    bit          rnd_pc  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] next_pc(input logic [31:0] cur);
        int r;
        if (!rnd_pc) return cur + 32'd4;
        r = int'($urandom_range(0, 99));
        if (r < 5)  return cur + 32'd2;
        if (r < 10) return $urandom & 32'hFFFF_FFFC;
        return (cur + 32'd4) & 32'hFFFF_FFFC;
    endfunction

    task automatic finish_fetch(input logic [31:0] word, input bit bad);
        m_phase = PH_HOLD;
        m_valid = 1'b1;
        m_instr = word;
        if (bad) m_err = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit rst_v, input bit stall_v, input bit ack_v,
                        input logic [31:0] rdata_v, input bit err_v);
        bit exp_pause;
        bit exp_req;
        bit mis;
        @(negedge Clock);
        nReset         = rst_v;
        stall_in       = stall_v;
        bus.imem_ack   = ack_v;
        bus.imem_rdata = rdata_v;
        bus.imem_err   = err_v;
        instr_addr     = pc;
        #1;
        mis       = (pc[1:0] != 2'b00);
        exp_pause = !rst_v || !m_known || (m_phase != PH_HOLD) || stall_v;
        check("pause", 64'(pause), 64'(exp_pause));
        if (m_known) begin
            exp_req = (m_phase == PH_WAIT) && !mis;
            check("imem_req", 64'(bus.imem_req), 64'(exp_req));
            if (exp_req) check("imem_addr", 64'(bus.imem_addr), 64'(pc));
            check("instr_valid", 64'(instr_valid), 64'(m_valid));
            check("instr", 64'(instr), 64'(m_instr));
            check("fetch_err", 64'(fetch_err), 64'(m_err));
            if (!instr_valid && !pause) check("pause_low_without_valid", 64'(pause), 64'd1);
        end
        if (!rst_v) begin
            m_known = 1'b1;
            m_phase = PH_IDLE;
            m_wait  = 0;
            m_instr = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    m_phase = PH_WAIT;
                    m_wait  = 0;
                end
                PH_WAIT: begin
                    if (mis)                                 finish_fetch('0, 1'b1);
                    else if (ack_v)                          finish_fetch(err_v ? 32'h0 : rdata_v, err_v);
                    else if (TMO != 0 && m_wait == TMO - 1)  finish_fetch('0, 1'b1);
                    else                                     m_wait++;
                end
                default: begin
                    if (!stall_v) begin
                        m_phase = PH_WAIT;
                        m_wait  = 0;
                        m_valid = 1'b0;
                        pc      = next_pc(pc);
                    end
                end
            endcase
        end
    endtask

    initial begin
        int          lat;
        bit          r_rst;
        bit          r_stall;
        bit          r_ack;
        bit          r_err;
        logic [31:0] r_data;

        nReset         = 1'b0;
        stall_in       = 1'b0;
        instr_addr     = '0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.imem_err   = 1'b0;
        lat            = 2;

        // Reset state, then a clean fetch of address 0 with ack on the 3rd request cycle.
        pc = 32'h0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("rst_pause", 64'(pause), 64'd1);
        check("rst_req", 64'(bus.imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_err", 64'(fetch_err), 64'd0);
        check("rst_addr", 64'(bus.imem_addr), 64'd0);
        step(1, 0, 0, 0, 0);
        check("t1_req", 64'(bus.imem_req), 64'd1);
        check("t1_addr", 64'(bus.imem_addr), 64'd0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 32'h8C22_0004, 0);
        check("t1_pause_in_req", 64'(pause), 64'd1);
        step(1, 1, 0, 0, 0);
        check("t1_instr", 64'(instr), 64'h8C22_0004);
        check("t1_valid", 64'(instr_valid), 64'd1);

        // Stall held for five cycles, then release and refetch at the new PC.
        repeat (4) step(1, 1, 0, 0, 0);
        check("t2_stall_pause", 64'(pause), 64'd1);
        check("t2_stall_noreq", 64'(bus.imem_req), 64'd0);
        check("t2_instr_stable", 64'(instr), 64'h8C22_0004);
        step(1, 0, 0, 0, 0);
        check("t2_release_pause", 64'(pause), 64'd0);

        // Bus error, then a good fetch: the error flag must stay set.
        step(1, 0, 1, 32'hFFFF_FFFF, 1);
        check("t2_req", 64'(bus.imem_req), 64'd1);
        check("t2_req_addr", 64'(bus.imem_addr), 64'h4);
        step(1, 0, 0, 0, 0);
        check("t3_instr_nop", 64'(instr), 64'd0);
        check("t3_err", 64'(fetch_err), 64'd1);
        step(1, 0, 1, 32'h1234_5678, 0);
        step(1, 0, 0, 0, 0);
        check("t3_good_instr", 64'(instr), 64'h1234_5678);
        check("t3_sticky_err", 64'(fetch_err), 64'd1);

        // Timeout after four request cycles with no ack.
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("t4_req_last_cycle", 64'(bus.imem_req), 64'd1);
        step(1, 1, 0, 0, 0);
        check("t4_req_dropped", 64'(bus.imem_req), 64'd0);
        check("t4_instr_nop", 64'(instr), 64'd0);
        check("t4_valid", 64'(instr_valid), 64'd1);
        check("t4_err", 64'(fetch_err), 64'd1);

        // Misaligned PC: no request, straight to a NOP with the error flag.
        step(1, 0, 0, 0, 0);
        pc = 32'h6;
        step(1, 0, 0, 0, 0);
        check("t5_noreq", 64'(bus.imem_req), 64'd0);
        step(1, 1, 0, 0, 0);
        check("t5_instr_nop", 64'(instr), 64'd0);
        check("t5_valid", 64'(instr_valid), 64'd1);
        check("t5_err", 64'(fetch_err), 64'd1);

        // Fresh reset; ack on the last allowed cycle beats the timeout.
        pc = 32'h20;
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 32'hCAFE_F00D, 0);
        step(1, 1, 0, 0, 0);
        check("t4b_instr", 64'(instr), 64'hCAFE_F00D);
        check("t4b_err", 64'(fetch_err), 64'd0);
        check("t4b_valid", 64'(instr_valid), 64'd1);

        // Ack while holding an instruction is ignored.
        step(1, 1, 1, 32'hDEAD_BEEF, 1);
        step(1, 1, 0, 0, 0);
        check("t6_valid_ack_instr", 64'(instr), 64'hCAFE_F00D);
        check("t6_valid_ack_err", 64'(fetch_err), 64'd0);

        // Reset in the middle of a request, with a late ack after it.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("t6_req_before_rst", 64'(bus.imem_req), 64'd1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h1111_1111, 0);
        check("t6_rst_req", 64'(bus.imem_req), 64'd0);
        check("t6_rst_valid", 64'(instr_valid), 64'd0);
        check("t6_rst_instr", 64'(instr), 64'd0);
        check("t6_rst_pause", 64'(pause), 64'd1);
        step(1, 0, 0, 0, 0);
        check("t6_fresh_req", 64'(bus.imem_req), 64'd1);
        check("t6_late_ack_ignored", 64'(instr_valid), 64'd0);

        // Randomized traffic: memory latency 1..6 cycles, stalls, spurious acks, resets.
        rnd_pc = 1'b1;
        repeat (3000) begin
            r_rst   = ($urandom_range(0, 99) != 0);
            r_stall = ($urandom_range(0, 99) < 40);
            r_err   = ($urandom_range(0, 9) == 0);
            r_data  = $urandom;
            if (m_phase == PH_WAIT && pc[1:0] == 2'b00) r_ack = (m_wait + 1 == lat);
            else if (m_phase == PH_WAIT)               r_ack = 1'b0;
            else                                       r_ack = ($urandom_range(0, 9) == 0);
            step(r_rst, r_stall, r_ack, r_data, r_err);
            if (m_phase == PH_WAIT && m_wait == 0) lat = int'($urandom_range(1, 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
